// File: rtl/sargantana_icache_pkg.sv
// Shared icache constants and way/PLRU types for the tag compare and replacement logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sargantana_icache_pkg;

  localparam int ICACHE_N_WAY   = 4;
  localparam int TAG_DEPTH      = 64;
  localparam int TAG_WIDHT      = 20;
  localparam int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH);
  localparam int PLRU_LVL       = $clog2(ICACHE_N_WAY);

  typedef logic [ICACHE_N_WAY-1:0] way_onehot_t;
  typedef logic [ICACHE_N_WAY-2:0] plru_bits_t;

  // True when exactly one bit is set.
  function automatic logic is_onehot(way_onehot_t w);
    return (w != '0) && ((w & (w - way_onehot_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/sargantana_plru_tree.sv
// Tree pseudo-LRU helper: victim of a state and the state after touching one way.
// Latency: purely combinational.
// Backpressure: none; no handshake.
module sargantana_plru_tree
  import sargantana_icache_pkg::*;
(
  input  plru_bits_t  state_i,
  input  way_onehot_t access_i,
  output way_onehot_t victim_o,
  output plru_bits_t  state_o
);

  // Walk from the root along the node bits down to the leaf they point at.
  always_comb begin
    int node;
    int leaf;
    node     = 0;
    leaf     = 0;
    victim_o = '0;
    for (int l = 0; l < PLRU_LVL; l++) begin
      leaf = 2 * leaf + int'(state_i[PLRU_LVL'(node)]);
      node = 2 * node + 1 + int'(state_i[PLRU_LVL'(node)]);
    end
    victim_o[PLRU_LVL'(leaf)] = 1'b1;
  end

  // Make every node on the path to the accessed way point to the other half.
  always_comb begin
    int   way;
    int   node;
    logic dir;
    way = 0;
    for (int w = ICACHE_N_WAY - 1; w >= 0; w--) begin
      if (access_i[w]) way = w;
    end
    state_o = state_i;
    node    = 0;
    for (int l = 0; l < PLRU_LVL; l++) begin
      dir = 1'(way >> (PLRU_LVL - 1 - l));
      state_o[PLRU_LVL'(node)] = ~dir;
      node = 2 * node + 1 + int'(dir);
    end
  end

endmodule

// File: rtl/sargantana_itag_cmp_plru.sv
// Icache tag compare (hit / one-hot hit way / miss / multi-hit) with per-set tree PLRU victim pick.
// Latency: results 1 cycle after lookup_valid_i, combinational from the S1 tag read data.
// Backpressure: none; kill_i drops the S1 lookup, flush_i clears replacement state.
module sargantana_itag_cmp_plru
  import sargantana_icache_pkg::*;
(
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   lookup_valid_i,
  input  logic [TAG_ADDR_WIDHT-1:0]              lookup_idx_i,
  input  logic [TAG_WIDHT-1:0]                   ptag_i,
  input  logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0] tag_way_i,
  input  logic [ICACHE_N_WAY-1:0]                vbit_i,
  input  logic                                   kill_i,
  input  logic                                   flush_i,
  input  logic                                   refill_done_i,
  input  logic [TAG_ADDR_WIDHT-1:0]              refill_idx_i,
  input  logic [ICACHE_N_WAY-1:0]                refill_way_i,
  output logic                                   hit_o,
  output logic                                   miss_o,
  output logic [ICACHE_N_WAY-1:0]                way_hit_o,
  output logic [ICACHE_N_WAY-1:0]                victim_way_o,
  output logic                                   multi_hit_o
);

  logic                      s1_valid_q;
  logic [TAG_ADDR_WIDHT-1:0] s1_idx_q;
  plru_bits_t                plru_q [TAG_DEPTH];
  plru_bits_t                plru_d [TAG_DEPTH];

  way_onehot_t match;
  way_onehot_t hit_way;
  way_onehot_t inv_way;
  way_onehot_t tree_victim;
  way_onehot_t rf_victim_unused;
  plru_bits_t  rf_next;
  plru_bits_t  hit_state;
  plru_bits_t  hit_next;
  logic        act;
  logic        rf_upd;
  logic        same_set;

  // Per-way tag compare against the physical tag.
  always_comb begin
    match = '0;
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      match[w] = vbit_i[w] & (tag_way_i[w] == ptag_i);
    end
  end

  assign act         = s1_valid_q & ~kill_i & ~flush_i;
  assign hit_o       = act & (|match);
  assign miss_o      = act & ~(|match);
  assign way_hit_o   = act ? match : '0;
  assign multi_hit_o = act & ((match & (match - way_onehot_t'(1))) != '0);

  // Lowest matching way drives the PLRU touch; lowest invalid way is the preferred victim.
  assign hit_way = match & (~match + way_onehot_t'(1));
  assign inv_way = ~vbit_i & (vbit_i + way_onehot_t'(1));

  assign victim_way_o = !miss_o    ? '0 :
                        (&vbit_i)  ? tree_victim : inv_way;

  // Malformed refill way masks leave the set untouched.
  assign rf_upd   = refill_done_i & is_onehot(refill_way_i);
  assign same_set = rf_upd & (refill_idx_i == s1_idx_q);

  // The hit tree sees the refilled state only when it actually updates, so a miss
  // always picks its victim from the stored state.
  assign hit_state = (same_set & hit_o) ? rf_next : plru_q[s1_idx_q];

  sargantana_plru_tree u_rf_tree (
    .state_i  (plru_q[refill_idx_i]),
    .access_i (refill_way_i),
    .victim_o (rf_victim_unused),
    .state_o  (rf_next)
  );

  sargantana_plru_tree u_hit_tree (
    .state_i  (hit_state),
    .access_i (hit_way),
    .victim_o (tree_victim),
    .state_o  (hit_next)
  );

  // Next PLRU array: flush wins, else refill then hit (hit last so it wins on a shared set).
  always_comb begin
    plru_d = plru_q;
    if (flush_i) begin
      plru_d = '{default: '0};
    end else begin
      if (rf_upd) plru_d[refill_idx_i] = rf_next;
      if (hit_o)  plru_d[s1_idx_q]     = hit_next;
    end
  end

  // S0->S1 lookup register and PLRU storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      plru_q     <= '{default: '0};
    end else begin
      s1_valid_q <= lookup_valid_i & ~flush_i;
      s1_idx_q   <= lookup_idx_i;
      plru_q     <= plru_d;
    end
  end

endmodule

// File: tb/tb_sargantana_itag_cmp_plru.sv
// Self-checking bench for sargantana_itag_cmp_plru: directed table plus randomized model check.
// Latency: checks outputs each cycle, 1 ns after inputs are applied.
// Backpressure: n/a.
module tb_sargantana_itag_cmp_plru;
  import sargantana_icache_pkg::*;

  logic                                   clk_i = 1'b0;
  logic                                   rst_i;
  logic                                   lookup_valid_i;
  logic [TAG_ADDR_WIDHT-1:0]              lookup_idx_i;
  logic [TAG_WIDHT-1:0]                   ptag_i;
  logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0] tag_way_i;
  logic [ICACHE_N_WAY-1:0]                vbit_i;
  logic                                   kill_i;
  logic                                   flush_i;
  logic                                   refill_done_i;
  logic [TAG_ADDR_WIDHT-1:0]              refill_idx_i;
  logic [ICACHE_N_WAY-1:0]                refill_way_i;
  logic                                   hit_o;
  logic                                   miss_o;
  logic [ICACHE_N_WAY-1:0]                way_hit_o;
  logic [ICACHE_N_WAY-1:0]                victim_way_o;
  logic                                   multi_hit_o;

  sargantana_itag_cmp_plru dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .lookup_valid_i (lookup_valid_i),
    .lookup_idx_i   (lookup_idx_i),
    .ptag_i         (ptag_i),
    .tag_way_i      (tag_way_i),
    .vbit_i         (vbit_i),
    .kill_i         (kill_i),
    .flush_i        (flush_i),
    .refill_done_i  (refill_done_i),
    .refill_idx_i   (refill_idx_i),
    .refill_way_i   (refill_way_i),
    .hit_o          (hit_o),
    .miss_o         (miss_o),
    .way_hit_o      (way_hit_o),
    .victim_way_o   (victim_way_o),
    .multi_hit_o    (multi_hit_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic                                   rst;
    logic                                   lv;
    logic [TAG_ADDR_WIDHT-1:0]              lidx;
    logic [TAG_WIDHT-1:0]                   ptag;
    logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0] tags;
    logic [ICACHE_N_WAY-1:0]                vbit;
    logic                                   kill;
    logic                                   flush;
    logic                                   rd;
    logic [TAG_ADDR_WIDHT-1:0]              ridx;
    logic [ICACHE_N_WAY-1:0]                rway;
  } vec_t;

  typedef struct packed {
    logic                    hit;
    logic                    miss;
    logic [ICACHE_N_WAY-1:0] wh;
    logic [ICACHE_N_WAY-1:0] vic;
    logic                    mh;
  } out_t;

  typedef struct {
    vec_t v;
    out_t e;
    bit   chk;
  } row_t;

  localparam logic [19:0] P  = 20'h12345;
  localparam logic [19:0] A0 = 20'hAAAA0;
  localparam logic [19:0] A1 = 20'hAAAA1;
  localparam logic [19:0] A2 = 20'hAAAA2;
  localparam logic [19:0] A3 = 20'hAAAA3;
  localparam logic [3:0][19:0] NOM   = {A3, A2, A1, A0};
  localparam logic [3:0][19:0] HIT0  = {A3, A2, A1, P};
  localparam logic [3:0][19:0] HIT2  = {A3, P, A1, A0};
  localparam logic [3:0][19:0] HIT3  = {P, A2, A1, A0};
  localparam logic [3:0][19:0] HIT13 = {P, A2, P, A0};

  int nvec = 0;
  int nerr = 0;

  // Reference model: per-set tree of "victim is in upper half" flags, walked by way ranges.
  bit mtree [TAG_DEPTH][ICACHE_N_WAY-1];
  bit m_valid;
  int m_idx;

  function automatic void model_clear();
    for (int s = 0; s < TAG_DEPTH; s++)
      for (int n = 0; n < ICACHE_N_WAY - 1; n++) mtree[s][n] = 1'b0;
  endfunction

  function automatic int model_victim(int set);
    int lo = 0, span = ICACHE_N_WAY, node = 0, half;
    while (span > 1) begin
      half = span / 2;
      if (mtree[set][node]) begin lo += half; node = 2 * node + 2; end
      else                  node = 2 * node + 1;
      span = half;
    end
    return lo;
  endfunction

  function automatic void model_touch(int set, int way);
    int lo = 0, span = ICACHE_N_WAY, node = 0, half;
    while (span > 1) begin
      half = span / 2;
      if (way < lo + half) begin mtree[set][node] = 1'b1; node = 2 * node + 1; end
      else begin mtree[set][node] = 1'b0; lo += half; node = 2 * node + 2; end
      span = half;
    end
  endfunction

  function automatic out_t model_out(vec_t v);
    out_t o;
    int   cnt = 0;
    int   inv = -1;
    bit   act;
    logic [ICACHE_N_WAY-1:0] m;
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      m[w] = v.vbit[w] && (v.tags[w] == v.ptag);
      if (m[w]) cnt++;
    end
    for (int w = ICACHE_N_WAY - 1; w >= 0; w--) if (!v.vbit[w]) inv = w;
    act    = m_valid && !v.kill && !v.flush;
    o.hit  = act && (cnt > 0);
    o.miss = act && (cnt == 0);
    o.wh   = act ? m : '0;
    o.mh   = act && (cnt > 1);
    o.vic  = '0;
    if (o.miss) begin
      if (inv >= 0) o.vic = 4'(1 << inv);
      else          o.vic = 4'(1 << model_victim(m_idx));
    end
    return o;
  endfunction

  function automatic void model_tick(vec_t v);
    out_t o;
    int   cnt = 0, rw = 0, hw = 0;
    if (v.rst) begin
      model_clear();
      m_valid = 1'b0;
      m_idx   = 0;
      return;
    end
    o = model_out(v);
    if (v.flush) model_clear();
    else begin
      for (int w = 0; w < ICACHE_N_WAY; w++) if (v.rway[w]) begin cnt++; rw = w; end
      if (v.rd && cnt == 1) model_touch(int'(v.ridx), rw);
      if (o.hit) begin
        for (int w = ICACHE_N_WAY - 1; w >= 0; w--) if (o.wh[w]) hw = w;
        model_touch(m_idx, hw);
      end
    end
    m_valid = v.lv && !v.flush;
    m_idx   = int'(v.lidx);
  endfunction

  function automatic row_t mk(bit rst, bit lv, int lidx, logic [3:0][19:0] tags, logic [3:0] vbit,
                              bit kill, bit flush, bit rd, int ridx, logic [3:0] rway,
                              bit h, bit m, logic [3:0] wh, logic [3:0] vic, bit mh, bit chk);
    row_t r;
    r.v.rst = rst;   r.v.lv = lv;       r.v.lidx = 6'(lidx);
    r.v.ptag = P;    r.v.tags = tags;   r.v.vbit = vbit;
    r.v.kill = kill; r.v.flush = flush; r.v.rd = rd;
    r.v.ridx = 6'(ridx); r.v.rway = rway;
    r.e.hit = h; r.e.miss = m; r.e.wh = wh; r.e.vic = vic; r.e.mh = mh;
    r.chk = chk;
    return r;
  endfunction

  task automatic drive(vec_t v);
    rst_i          = v.rst;
    lookup_valid_i = v.lv;
    lookup_idx_i   = v.lidx;
    ptag_i         = v.ptag;
    tag_way_i      = v.tags;
    vbit_i         = v.vbit;
    kill_i         = v.kill;
    flush_i        = v.flush;
    refill_done_i  = v.rd;
    refill_idx_i   = v.ridx;
    refill_way_i   = v.rway;
  endtask

  task automatic step(vec_t v, bit chk, out_t exp, string name);
    out_t got;
    drive(v);
    #1;
    if (chk) begin
      got = {hit_o, miss_o, way_hit_o, victim_way_o, multi_hit_o};
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL %s: got hit=%0b miss=%0b way_hit=%b victim=%b multi=%0b, want hit=%0b miss=%0b way_hit=%b victim=%b multi=%0b",
                 name, got.hit, got.miss, got.wh, got.vic, got.mh, exp.hit, exp.miss, exp.wh, exp.vic, exp.mh);
      end
    end
    @(posedge clk_i);
    model_tick(v);
    #1;
  endtask

  row_t tbl[$];

  initial begin
    vec_t v;
    out_t e;
    model_clear();
    m_valid = 1'b0;
    m_idx   = 0;

    // rst lv idx tags vbit kill flush rd ridx rway | hit miss wh vic mh | chk
    tbl.push_back(mk(1,0,0, NOM,4'hF, 0,0, 0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 0));
    tbl.push_back(mk(1,0,0, NOM,4'hF, 0,0, 0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 0));
    tbl.push_back(mk(0,0,0, NOM,4'hF, 0,0, 0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 1));  // reset state
    tbl.push_back(mk(0,1,5, NOM,4'hF, 0,0, 0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 1));
    tbl.push_back(mk(0,0,0, NOM,4'h0, 0,0, 0,0,4'b0000, 0,1,4'b0000,4'b0001,0, 1));  // cold miss
    tbl.push_back(mk(0,1,7, NOM,4'hF, 0,0, 0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 1));
    tbl.push_back(mk(0,1,7, HIT2,4'hF,0,0, 0,0,4'b0000, 1,0,4'b0100,4'b0000,0, 1));  // hit way2
    tbl.push_back(mk(0,0,0, NOM,4'hF, 0,0, 0,0,4'b0000, 0,1,4'b0000,4'b0001,0, 1));
    tbl.push_back(mk(0,0,0, NOM,4'hF, 0,0, 1,3,4'b0001, 0,0,4'b0000,4'b0000,0, 1));  // refill w0
    tbl.push_back(mk(0,1,3, NOM,4'hF, 0,0, 1,3,4'b0010, 0,0,4'b0000,4'b0000,0, 1));  // refill w1
    tbl.push_back(mk(0,1,3, NOM,4'hF, 0,0, 0,0,4'b0000, 0,1,4'b0000,4'b0100,0, 1));
    tbl.push_back(mk(0,1,3, HIT2,4'hF,0,0, 0,0,4'b0000, 1,0,4'b0100,4'b0000,0, 1));
    tbl.push_back(mk(0,1,3, NOM,4'hF, 0,0, 1,3,4'b0001, 0,1,4'b0000,4'b0001,0, 1));
    tbl.push_back(mk(0,0,0, NOM,4'hF, 0,0, 0,0,4'b0000, 0,1,4'b0000,4'b1000,0, 1));
    tbl.push_back(mk(0,1,3, NOM,4'hF, 0,1, 0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 1));  // flush
    tbl.push_back(mk(0,1,3, NOM,4'hF, 0,0, 0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 1));  // S0 dropped
    tbl.push_back(mk(0,1,3, NOM,4'hF, 0,0, 0,0,4'b0000, 0,1,4'b0000,4'b0001,0, 1));
    tbl.push_back(mk(0,1,3, HIT0,4'hF,0,1, 0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 1));  // flush in S1
    tbl.push_back(mk(0,1,3, HIT0,4'hF,0,0, 0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 1));
    tbl.push_back(mk(0,0,0, NOM,4'hF, 0,0, 0,0,4'b0000, 0,1,4'b0000,4'b0001,0, 1));
    tbl.push_back(mk(0,1,9, NOM,4'hF, 0,0, 0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 1));
    tbl.push_back(mk(0,1,9, HIT3,4'hF,0,0, 1,9,4'b0001, 1,0,4'b1000,4'b0000,0, 1));  // hit+refill same set
    tbl.push_back(mk(0,1,9, NOM,4'hF, 0,0, 0,0,4'b0000, 0,1,4'b0000,4'b0010,0, 1));
    tbl.push_back(mk(0,1,10,NOM,4'hE, 0,0, 0,0,4'b0000, 0,1,4'b0000,4'b0001,0, 1));  // invalid way0 first
    tbl.push_back(mk(0,0,0, HIT0,4'hF,0,0, 1,11,4'b0001,1,0,4'b0001,4'b0000,0, 1));  // different sets
    tbl.push_back(mk(0,1,10,NOM,4'hF, 0,0, 0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 1));
    tbl.push_back(mk(0,1,11,NOM,4'hF, 0,0, 0,0,4'b0000, 0,1,4'b0000,4'b0100,0, 1));
    tbl.push_back(mk(0,0,0, NOM,4'hF, 0,0, 0,0,4'b0000, 0,1,4'b0000,4'b0100,0, 1));
    tbl.push_back(mk(0,1,12,NOM,4'hF, 0,0, 0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 1));
    tbl.push_back(mk(0,1,12,HIT13,4'hF,0,0,0,0,4'b0000, 1,0,4'b1010,4'b0000,1, 1));  // multi-hit
    tbl.push_back(mk(0,1,12,NOM,4'hF, 0,0, 0,0,4'b0000, 0,1,4'b0000,4'b0100,0, 1));
    tbl.push_back(mk(0,0,0, HIT13,4'hF,1,0,1,12,4'b1000,0,0,4'b0000,4'b0000,0, 1));  // kill + refill
    tbl.push_back(mk(0,1,12,NOM,4'hF, 0,0, 0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 1));
    tbl.push_back(mk(0,1,12,NOM,4'hF, 0,0, 1,12,4'b0011,0,1,4'b0000,4'b0001,0, 1));  // illegal refill
    tbl.push_back(mk(0,1,12,NOM,4'hF, 0,0, 1,12,4'b0000,0,1,4'b0000,4'b0001,0, 1));  // empty refill
    tbl.push_back(mk(0,0,0, NOM,4'hF, 0,0, 0,0,4'b0000, 0,1,4'b0000,4'b0001,0, 1));
    tbl.push_back(mk(0,1,12,NOM,4'hF, 0,0, 0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 1));
    tbl.push_back(mk(1,0,0, HIT13,4'hF,0,0,0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 0));  // reset mid-lookup
    tbl.push_back(mk(0,0,0, HIT13,4'hF,0,0,0,0,4'b0000, 0,0,4'b0000,4'b0000,0, 1));

    foreach (tbl[i]) step(tbl[i].v, tbl[i].chk, tbl[i].e, $sformatf("tbl[%0d]", i));

    for (int i = 0; i < 3000; i++) begin
      v.rst   = ($urandom_range(0, 499) == 0);
      v.lv    = ($urandom_range(0, 3) != 0);
      v.lidx  = 6'($urandom_range(0, 3));
      v.ptag  = 20'($urandom);
      for (int w = 0; w < ICACHE_N_WAY; w++)
        v.tags[w] = ($urandom_range(0, 3) == 0) ? v.ptag : 20'($urandom);
      v.vbit  = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
      v.kill  = ($urandom_range(0, 15) == 0);
      v.flush = ($urandom_range(0, 39) == 0);
      v.rd    = ($urandom_range(0, 3) == 0);
      v.ridx  = 6'($urandom_range(0, 3));
      v.rway  = ($urandom_range(0, 7) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      e = model_out(v);
      step(v, 1'b1, e, $sformatf("rnd[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
